// File: rtl/dec3_sel_sequencer_pkg.sv
// ============================================================================
// dec3_sel_sequencer_pkg
// Shared state encoding and select-width constants for the select sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

package dec3_sel_sequencer_pkg;

   localparam int NUM_SEL = 8;
   localparam int SEL_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   function automatic logic is_last_step(input logic [SEL_W-1:0] step_cnt);
      return step_cnt == SEL_W'(NUM_SEL - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dec3_sel_sequencer_sel_updown_ctr.sv
// ============================================================================
// sel_updown_ctr
// 3-bit load/step code counter, mod-8 up or down, with a registered wrap pulse.
// Rev 1.0
// ============================================================================
`default_nettype none

module sel_updown_ctr
   import dec3_sel_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [SEL_W-1:0] load_val,
   input  logic             step,
   input  logic             dir_down,
   output logic [SEL_W-1:0] sel,
   output logic             wrap
);

   logic [SEL_W-1:0] r_sel;
   logic             r_wrap;
   logic [SEL_W-1:0] w_next;
   logic             w_wrap;

   assign w_next = dir_down ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));
   assign w_wrap = dir_down ? (r_sel == '0) : (r_sel == '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel  <= '0;
         r_wrap <= 1'b0;
      end else if (load) begin
         r_sel  <= load_val;
         r_wrap <= 1'b0;
      end else if (step) begin
         r_sel  <= w_next;
         r_wrap <= w_wrap;
      end else begin
         r_wrap <= 1'b0;
      end
   end

   assign sel  = r_sel;
   assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: rtl/dec3_sel_sequencer.sv
// ============================================================================
// dec3_sel_sequencer
// Walks a 3-to-8 decoder's {A,B,C} selects through all eight codes with dwell.
// Rev 1.0
// ============================================================================
`default_nettype none

module dec3_sel_sequencer
   import dec3_sel_sequencer_pkg::*;
#(
   parameter int DWELL_W = 4
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               mode_cont,
   input  logic               dir_down,
   input  logic [SEL_W-1:0]   start_sel,
   input  logic [DWELL_W-1:0] dwell,
   output logic               A,
   output logic               B,
   output logic               C,
   output logic               sel_valid,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   state_t             r_state;
   logic               r_cont;
   logic               r_dir_down;
   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] r_dwell_cnt;
   logic [SEL_W-1:0]   r_step_cnt;
   logic               r_busy;
   logic               r_done;
   logic               r_sel_valid;

   logic               w_load;
   logic               w_expire;
   logic               w_last;
   logic               w_step;
   logic [SEL_W-1:0]   w_sel;

   assign w_load   = (r_state == ST_IDLE) && start;
   assign w_expire = (r_state == ST_RUN) && !stop && (r_dwell_cnt == '0);
   assign w_last   = !r_cont && is_last_step(r_step_cnt);
   // The final single-pass expiry ends the run instead of stepping, so no wrap.
   assign w_step   = w_expire && !w_last;

   sel_updown_ctr u_sel_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .load_val (start_sel),
      .step     (w_step),
      .dir_down (r_dir_down),
      .sel      (w_sel),
      .wrap     (wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cont      <= 1'b0;
         r_dir_down  <= 1'b0;
         r_dwell     <= '0;
         r_dwell_cnt <= '0;
         r_step_cnt  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_sel_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_cont      <= mode_cont;
                  r_dir_down  <= dir_down;
                  r_dwell     <= dwell;
                  r_dwell_cnt <= dwell;
                  r_step_cnt  <= '0;
                  r_busy      <= 1'b1;
                  r_sel_valid <= 1'b1;
                  r_state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (stop || ((r_dwell_cnt == '0) && w_last)) begin
                  r_busy      <= 1'b0;
                  r_sel_valid <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= ST_FIN;
               end else if (r_dwell_cnt == '0) begin
                  r_dwell_cnt <= r_dwell;
                  r_step_cnt  <= r_step_cnt + SEL_W'(1);
               end else begin
                  r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
               end
            end
            ST_FIN: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy      <= 1'b0;
               r_sel_valid <= 1'b0;
               r_done      <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign A         = w_sel[2];
   assign B         = w_sel[1];
   assign C         = w_sel[0];
   assign sel_valid = r_sel_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_dec3_sel_sequencer.sv
// ============================================================================
// tb_dec3_sel_sequencer
// Directed vector table plus hand-written multi-cycle sequences.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dec3_sel_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic       mode_cont;
   logic       dir_down;
   logic [2:0] start_sel;
   logic [3:0] dwell;
   logic       A, B, C;
   logic       sel_valid, busy, done, wrap;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic       start;
      logic       stop;
      logic       cont;
      logic       dn;
      logic [2:0] ssel;
      logic [3:0] dwl;
      logic [2:0] code;
      logic       v;
      logic       b;
      logic       d;
      logic       w;
   } vec_t;

   vec_t vt[10];

   dec3_sel_sequencer #(.DWELL_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .mode_cont (mode_cont),
      .dir_down  (dir_down),
      .start_sel (start_sel),
      .dwell     (dwell),
      .A         (A),
      .B         (B),
      .C         (C),
      .sel_valid (sel_valid),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] pack_exp(input logic [2:0] code, input logic v,
                                           input logic b, input logic d, input logic w);
      return {code, v, b, d, w};
   endfunction

   task automatic check(input string name, input logic [6:0] exp);
      logic [6:0] act;
      act = {A, B, C, sel_valid, busy, done, wrap};
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got {ABC,valid,busy,done,wrap}=%b required %b at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic launch(input logic [2:0] s, input logic [3:0] d,
                         input logic dn, input logic cont);
      start     = 1'b1;
      start_sel = s;
      dwell     = d;
      dir_down  = dn;
      mode_cont = cont;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      logic [2:0] down_codes [8];
      logic [2:0] code;
      int         dones;

      down_codes = '{3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};

      // single up pass, dwell 0: codes 0..7 then FIN then IDLE
      vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 1; i < 8; i++)
         vt[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 3'(i), 1'b1, 1'b1, 1'b0, 1'b0};
      vt[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
      dir_down = 1'b0; start_sel = 3'd0; dwell = 4'd0;
      #2;
      check("reset", pack_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("idle_after_reset", pack_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      for (int i = 0; i < 10; i++) begin
         start     = vt[i].start;
         stop      = vt[i].stop;
         mode_cont = vt[i].cont;
         dir_down  = vt[i].dn;
         start_sel = vt[i].ssel;
         dwell     = vt[i].dwl;
         tick();
         check($sformatf("up_vec%0d", i),
               pack_exp(vt[i].code, vt[i].v, vt[i].b, vt[i].d, vt[i].w));
      end
      start = 1'b0;

      // down from 2, dwell 2: each code 3 cycles, wrap on entry to 7
      launch(3'd2, 4'd2, 1'b1, 1'b0);
      for (int i = 0; i < 24; i++) begin
         if (i > 0) tick();
         check($sformatf("down_c%0d", i),
               pack_exp(down_codes[i / 3], 1'b1, 1'b1, 1'b0, (i == 9)));
      end
      tick();
      check("down_done", pack_exp(3'd3, 1'b0, 1'b0, 1'b1, 1'b0));
      tick();
      check("down_idle", pack_exp(3'd3, 1'b0, 1'b0, 1'b0, 1'b0));

      // continuous up from 6, dwell 1; a start mid-run must be ignored
      launch(3'd6, 4'd1, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         if (i > 0) begin
            if (i == 5) begin
               start = 1'b1; start_sel = 3'd3; dwell = 4'd0; dir_down = 1'b1;
            end
            tick();
            start = 1'b0;
         end
         code = 3'((6 + i / 2) % 8);
         check($sformatf("cont_c%0d", i),
               pack_exp(code, 1'b1, 1'b1, 1'b0, (i > 0) && (i % 2 == 0) && (code == 3'd0)));
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("cont_stop_done", pack_exp(3'd7, 1'b0, 1'b0, 1'b1, 1'b0));
      tick();
      check("cont_stop_idle", pack_exp(3'd7, 1'b0, 1'b0, 1'b0, 1'b0));

      // stop coincident with the final dwell expiry: exactly one done
      launch(3'd0, 4'd0, 1'b0, 1'b0);
      for (int i = 1; i < 8; i++) tick();
      check("coinc_last_code", pack_exp(3'd7, 1'b1, 1'b1, 1'b0, 1'b0));
      stop  = 1'b1;
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         stop = 1'b0;
         if (done) dones++;
      end
      check_int("coinc_done_count", dones, 1);

      // stop in IDLE is ignored
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_in_idle", pack_exp(3'd7, 1'b0, 1'b0, 1'b0, 1'b0));

      // max dwell: each code held 16 cycles
      launch(3'd5, 4'd15, 1'b0, 1'b0);
      for (int i = 0; i < 128; i++) begin
         if (i > 0) tick();
         code = 3'((5 + i / 16) % 8);
         check($sformatf("dw15_c%0d", i),
               pack_exp(code, 1'b1, 1'b1, 1'b0, (i > 0) && (i % 16 == 0) && (code == 3'd0)));
      end
      tick();
      check("dw15_done", pack_exp(3'd4, 1'b0, 1'b0, 1'b1, 1'b0));
      tick();

      // asynchronous reset mid-run
      launch(3'd5, 4'd3, 1'b0, 1'b1);
      tick();
      tick();
      check("pre_reset_run", pack_exp(3'd5, 1'b1, 1'b1, 1'b0, 1'b0));
      #3 rst = 1'b1;
      #1;
      check("async_reset_midrun", pack_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("idle_after_midrun_reset", pack_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      tick();
      check("no_done_after_reset", pack_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
